// File: rtl/sd_interpolation.sv
`default_nettype none
// ============================================================================
// Module   : sd_interpolation
// Purpose  : Sigma-delta DAC front end: linear-interpolating upsampler (xOSR)
//            feeding a first-order 1-bit error-feedback modulator.
// Revision : 1.0 - initial release
// ============================================================================
module sd_interpolation #(
  parameter int IN_W     = 24,
  parameter int OSR      = 64,
  parameter int LOG2_OSR = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clr_underrun,
  output logic            bit_out,
  output logic [IN_W-1:0] interp_out,
  output logic            underrun,
  output logic            running
);

  localparam int ACC_W = IN_W + LOG2_OSR + 1;
  localparam int INT_W = IN_W + 2;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q,      state_d;
  logic [LOG2_OSR-1:0] phase_q,      phase_d;
  logic                buf_full_q,   buf_full_d;
  logic [IN_W-1:0]     buf_q,        buf_d;
  logic [IN_W-1:0]     base_q,       base_d;
  logic [IN_W-1:0]     target_q,     target_d;
  logic [ACC_W-1:0]    acc_q,        acc_d;
  logic [IN_W-1:0]     interp_out_q, interp_out_d;
  logic [INT_W-1:0]    integ_q,      integ_d;
  logic                bit_out_q,    bit_out_d;
  logic                underrun_q,   underrun_d;

  logic                boundary;
  logic                accept;
  logic                set_underrun;
  logic [IN_W:0]       delta;
  logic [INT_W-1:0]    fb;
  logic [INT_W-1:0]    sum;

  always_comb begin
    boundary     = (phase_q == LOG2_OSR'(OSR - 1));
    in_ready     = !buf_full_q || boundary;
    accept       = in_valid && in_ready;

    state_d      = state_q;
    phase_d      = phase_q + LOG2_OSR'(1);
    buf_full_d   = buf_full_q;
    buf_d        = buf_q;
    base_d       = base_q;
    target_d     = target_q;
    set_underrun = 1'b0;

    if (boundary) begin
      if (buf_full_q) begin
        base_d     = target_q;
        target_d   = buf_q;
        buf_full_d = 1'b0;
        state_d    = RUN;
      end else if (state_q == RUN) begin
        base_d       = target_q;
        set_underrun = 1'b1;
      end
    end

    // Consume and refill on the same boundary keeps the buffer full.
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    delta = {target_q[IN_W-1], target_q} - {base_q[IN_W-1], base_q};

    // Frame restarts at base*OSR; otherwise ramp by delta per cycle.
    if (boundary) acc_d = {base_d[IN_W-1], base_d, {LOG2_OSR{1'b0}}};
    else          acc_d = acc_q + {{LOG2_OSR{delta[IN_W]}}, delta};

    interp_out_d = acc_d[IN_W+LOG2_OSR-1:LOG2_OSR];

    fb        = bit_out_q ? {3'b001, {(IN_W-1){1'b0}}} : {3'b111, {(IN_W-1){1'b0}}};
    sum       = integ_q + {{2{interp_out_q[IN_W-1]}}, interp_out_q} - fb;
    integ_d   = sum;
    bit_out_d = !sum[INT_W-1];

    if (set_underrun)      underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      buf_full_q   <= 1'b0;
      buf_q        <= '0;
      base_q       <= '0;
      target_q     <= '0;
      acc_q        <= '0;
      interp_out_q <= '0;
      integ_q      <= '0;
      bit_out_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      buf_full_q   <= buf_full_d;
      buf_q        <= buf_d;
      base_q       <= base_d;
      target_q     <= target_d;
      acc_q        <= acc_d;
      interp_out_q <= interp_out_d;
      integ_q      <= integ_d;
      bit_out_q    <= bit_out_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign interp_out = interp_out_q;
  assign underrun   = underrun_q;
  assign running    = (state_q == RUN);

endmodule
`default_nettype wire
